// File: rtl/spi_reg_ctrl.sv
// Command/data byte controller sitting behind an SPI slave: decodes a command
// byte, then streams writes into or reads out of an 8x8 register file.
module spi_reg_ctrl #(
    parameter int unsigned AUTO_INC = 1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        ss,
    input  logic        data_rdy,
    input  logic [7:0]  spi_data_out,
    output logic [7:0]  spi_data_in,
    output logic        data_latch,
    input  logic        loc_we,
    input  logic [2:0]  loc_addr,
    input  logic [7:0]  loc_wdata,
    output logic        loc_ready,
    output logic [63:0] cfg_out,
    output logic        txn_done,
    output logic        cmd_err
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, ERR} state_t;

    state_t          state, next_state;
    logic            data_rdy_q;
    logic            byte_stb;
    logic [2:0]      ptr, ptr_next;
    logic [7:0][7:0] regs;
    logic            seen;
    logic            seen_set, seen_clr;
    logic            spi_wr, preload, err_set, done_set;
    logic [2:0]      preload_addr;
    logic [2:0]      cmd_addr;

    function automatic logic [2:0] adv(input logic [2:0] a);
        return (AUTO_INC != 0) ? a + 3'd1 : a;
    endfunction

    assign byte_stb  = data_rdy & ~data_rdy_q;
    assign cmd_addr  = spi_data_out[2:0];
    assign loc_ready = ~((state == WDATA) & byte_stb & ss);
    assign cfg_out   = regs;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        ptr_next     = ptr;
        preload_addr = ptr;
        spi_wr       = 1'b0;
        preload      = 1'b0;
        err_set      = 1'b0;
        done_set     = 1'b0;
        seen_set     = 1'b0;
        seen_clr     = 1'b0;
        if (state == IDLE) begin
            if (ss) begin
                next_state = CMD;
                seen_clr   = 1'b1;
            end
        end else if (!ss) begin
            // Deselect wins over a coincident byte strobe.
            next_state = IDLE;
            done_set   = seen;
        end else if (byte_stb) begin
            case (state)
                CMD: begin
                    if (|spi_data_out[6:3]) begin
                        next_state = ERR;
                        err_set    = 1'b1;
                    end else if (spi_data_out[7]) begin
                        preload      = 1'b1;
                        preload_addr = cmd_addr;
                        ptr_next     = adv(cmd_addr);
                        next_state   = RDATA;
                    end else begin
                        ptr_next   = cmd_addr;
                        next_state = WDATA;
                    end
                end
                WDATA: begin
                    spi_wr   = 1'b1;
                    ptr_next = adv(ptr);
                    seen_set = 1'b1;
                end
                RDATA: begin
                    preload  = 1'b1;
                    ptr_next = adv(ptr);
                    seen_set = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            data_rdy_q  <= 1'b0;
            ptr         <= '0;
            regs        <= '0;
            spi_data_in <= '0;
            data_latch  <= 1'b0;
            txn_done    <= 1'b0;
            cmd_err     <= 1'b0;
            seen        <= 1'b0;
        end else begin
            data_rdy_q <= data_rdy;
            ptr        <= ptr_next;
            data_latch <= preload;
            txn_done   <= done_set;
            cmd_err    <= err_set;
            if (seen_clr)      seen <= 1'b0;
            else if (seen_set) seen <= 1'b1;
            // Preload samples regs before this edge's write: read-before-write.
            if (preload) spi_data_in <= regs[preload_addr];
            if (spi_wr)                    regs[ptr]      <= spi_data_out;
            else if (loc_we && loc_ready)  regs[loc_addr] <= loc_wdata;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: a transaction-level model predicts
// latch/done/err events and register contents; a monitor checks events.
module tb_spi_reg_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss = 1'b0;
    logic        data_rdy = 1'b0;
    logic [7:0]  spi_data_out = '0;
    logic [7:0]  spi_data_in;
    logic        data_latch;
    logic        loc_we = 1'b0;
    logic [2:0]  loc_addr = '0;
    logic [7:0]  loc_wdata = '0;
    logic        loc_ready;
    logic [63:0] cfg_out;
    logic        txn_done;
    logic        cmd_err;

    spi_reg_ctrl #(.AUTO_INC(1)) dut (
        .sys_clk(sys_clk), .rst(rst), .ss(ss), .data_rdy(data_rdy),
        .spi_data_out(spi_data_out), .spi_data_in(spi_data_in),
        .data_latch(data_latch), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_ready(loc_ready), .cfg_out(cfg_out),
        .txn_done(txn_done), .cmd_err(cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       latch;
        logic       done;
        logic       err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         total = 0;
    int         bad = 0;

    // Model state: mode 0=command byte expected, 1=writing, 2=reading, 3=error
    int         m_mode;
    bit [2:0]   m_ptr;
    bit         m_seen;
    logic [7:0] m_regs [8];

    function automatic void push_ev(bit l, bit d, bit e, logic [7:0] v);
        ev_t x;
        x.latch = l; x.done = d; x.err = e; x.data = v;
        exp_q.push_back(x);
    endfunction

    function automatic logic [63:0] model_cfg();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!rst && (data_latch || txn_done || cmd_err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got latch=%0b done=%0b err=%0b data=%h expected none",
                         data_latch, txn_done, cmd_err, spi_data_in);
            end else begin
                mon_e = exp_q.pop_front();
                if ({data_latch, txn_done, cmd_err} !== {mon_e.latch, mon_e.done, mon_e.err} ||
                    (mon_e.latch && spi_data_in !== mon_e.data)) begin
                    bad++;
                    $display("FAIL event got latch=%0b done=%0b err=%0b data=%h expected latch=%0b done=%0b err=%0b data=%h",
                             data_latch, txn_done, cmd_err, spi_data_in,
                             mon_e.latch, mon_e.done, mon_e.err, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_mode)
            0: begin
                if (b[6:3] != 4'd0) begin
                    push_ev(0, 0, 1, 8'h00);
                    m_mode = 3;
                end else if (b[7]) begin
                    push_ev(1, 0, 0, m_regs[b[2:0]]);
                    m_ptr  = b[2:0] + 3'd1;
                    m_mode = 2;
                end else begin
                    m_ptr  = b[2:0];
                    m_mode = 1;
                end
            end
            1: begin
                m_regs[m_ptr] = b;
                m_ptr  = m_ptr + 3'd1;
                m_seen = 1;
            end
            2: begin
                push_ev(1, 0, 0, m_regs[m_ptr]);
                m_ptr  = m_ptr + 3'd1;
                m_seen = 1;
            end
            default: ;
        endcase
    endtask

    task automatic ss_begin();
        m_mode = 0;
        m_seen = 0;
        ss = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        spi_data_out = b;
        data_rdy = 1'b1;
        tick(); tick();
        data_rdy = 1'b0;
        tick(); tick();
    endtask

    // Byte strobe plus a local write on the same edge (used while reading).
    task automatic send_byte_loc(input logic [7:0] b, input logic [2:0] a, input logic [7:0] d);
        model_byte(b);
        m_regs[a] = d;
        spi_data_out = b;
        data_rdy = 1'b1;
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        tick();
        loc_we = 1'b0;
        tick();
        data_rdy = 1'b0;
        tick(); tick();
    endtask

    task automatic ss_finish();
        if (m_seen) push_ev(0, 1, 0, 8'h00);
        ss = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic abort_with_byte(input logic [7:0] b);
        if (m_seen) push_ev(0, 1, 0, 8'h00);
        ss = 1'b0;
        spi_data_out = b;
        data_rdy = 1'b1;
        tick(); tick();
        data_rdy = 1'b0;
        tick(); tick();
    endtask

    task automatic local_write(input logic [2:0] a, input logic [7:0] d);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge sys_clk);
        check("loc_ready_idle", {63'd0, loc_ready}, 64'd1);
        tick();
        loc_we = 1'b0;
        m_regs[a] = d;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_mode = 0; m_ptr = 0; m_seen = 0;

        // Reset state
        #12;
        check("rst_cfg_out", cfg_out, 64'd0);
        check("rst_spi_data_in", {56'd0, spi_data_in}, 64'd0);
        check("rst_loc_ready", {63'd0, loc_ready}, 64'd1);
        check("rst_pulses", {61'd0, data_latch, txn_done, cmd_err}, 64'd0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        tick(); tick();

        // Two-byte write from address 2
        ss_begin();
        send_byte(8'h02); send_byte(8'hA5); send_byte(8'h3C);
        ss_finish();
        check("wr_cfg", cfg_out, model_cfg());
        check("wr_reg2_reg3", {48'd0, cfg_out[31:16]}, 64'h3CA5);

        // Read wrapping 7 -> 0 -> 1
        local_write(3'd7, 8'h11);
        local_write(3'd0, 8'h22);
        ss_begin();
        send_byte(8'h87); send_byte(8'h00); send_byte(8'h00);
        ss_finish();
        check("rd_cfg", cfg_out, model_cfg());

        // Reserved bits set -> error, following byte ignored, no done
        ss_begin();
        send_byte(8'h48); send_byte(8'hFF);
        ss_finish();
        check("err_cfg", cfg_out, model_cfg());

        // SPI write collides with local write to the same address
        ss_begin();
        send_byte(8'h03);
        m_regs[3] = 8'h77; m_ptr = 3'd4; m_seen = 1;
        spi_data_out = 8'h99; data_rdy = 1'b1;
        loc_we = 1'b1; loc_addr = 3'd3; loc_wdata = 8'h77;
        @(negedge sys_clk);
        check("collide_loc_ready_low", {63'd0, loc_ready}, 64'd0);
        @(negedge sys_clk);
        check("collide_spi_first", {56'd0, cfg_out[31:24]}, 64'h99);
        check("collide_loc_ready_high", {63'd0, loc_ready}, 64'd1);
        @(posedge sys_clk); #1;
        loc_we = 1'b0;
        @(negedge sys_clk);
        check("collide_local_second", {56'd0, cfg_out[31:24]}, 64'h77);
        data_rdy = 1'b0;
        tick(); tick();
        ss_finish();
        check("collide_cfg", cfg_out, model_cfg());

        // Deselect coincides with second data byte
        ss_begin();
        send_byte(8'h05); send_byte(8'hAA);
        abort_with_byte(8'hBB);
        check("abort_cfg", cfg_out, model_cfg());

        // Read preload racing a local write to the same address
        local_write(3'd4, 8'h40);
        ss_begin();
        send_byte(8'h83);
        send_byte_loc(8'h00, 3'd4, 8'h44);
        send_byte(8'h00);
        ss_finish();
        check("rbw_cfg", cfg_out, model_cfg());

        // Reset mid-write, local write ignored during reset
        ss_begin();
        send_byte(8'h04); send_byte(8'hC3);
        rst = 1'b1; ss = 1'b0;
        loc_we = 1'b1; loc_addr = 3'd2; loc_wdata = 8'hEE;
        @(negedge sys_clk);
        check("midrst_cfg", cfg_out, 64'd0);
        check("midrst_loc_ready", {63'd0, loc_ready}, 64'd1);
        check("midrst_spi_data_in", {56'd0, spi_data_in}, 64'd0);
        tick();
        loc_we = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        tick(); tick();
        check("postrst_cfg", cfg_out, 64'd0);
        ss_begin();
        send_byte(8'h01); send_byte(8'h5A);
        ss_finish();
        check("postrst_write", cfg_out, model_cfg());

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            logic [7:0] cmd;
            int nb;
            if ($urandom_range(0, 2) == 0)
                local_write(3'($urandom_range(0, 7)), 8'($urandom));
            cmd = 8'($urandom);
            if ($urandom_range(0, 5) != 0) cmd[6:3] = 4'd0;
            nb = $urandom_range(0, 4);
            ss_begin();
            send_byte(cmd);
            for (int k = 0; k < nb; k++) send_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) abort_with_byte(8'($urandom));
            else ss_finish();
            check("rand_cfg", cfg_out, model_cfg());
        end

        tick(); tick();
        check("events_outstanding", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
